crc_stream_engine: RTL and testbench

//  Parametrised single-clock CRC generate/check engine with valid/ready handshakes on both sides.

---
 rtl/crc_stream_engine.sv | 163 ++++++++++++++++
 tb/tb_crc_stream_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// CRC generate/check engine: MSB-first long division by one of two polynomials,
// BPC bits per cycle, with valid/ready handshakes and a saturating check-failure counter.
module crc_stream_engine #(
   parameter int            MSG_W  = 60,
   parameter int            BPC    = 1,
   parameter int            PA_W   = 8,
   parameter logic [PA_W:0] POLY_A = 9'h131,
   parameter int            PB_W   = 5,
   parameter logic [PB_W:0] POLY_B = 6'h2B,
   parameter int            CNT_W  = 8
) (
   input  logic             clk_1,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MSG_W-1:0] in_msg,
   input  logic             in_mode,
   input  logic             in_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MSG_W-1:0] out_data,
   output logic             out_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int N  = MSG_W / BPC;
   localparam int RW = (PA_W > PB_W) ? PA_W : PB_W;
   localparam int CW = $clog2(N + 1);

   localparam logic [RW-1:0] MASK_A = RW'((32'd1 << PA_W) - 32'd1);
   localparam logic [RW-1:0] MASK_B = RW'((32'd1 << PB_W) - 32'd1);
   localparam logic [RW-1:0] POLY_A_LO = RW'(POLY_A[PA_W-1:0]);
   localparam logic [RW-1:0] POLY_B_LO = RW'(POLY_B[PB_W-1:0]);

   generate
      if ((MSG_W % BPC) != 0) begin : g_bad_bpc
         $error("crc_stream_engine: MSG_W must be a multiple of BPC");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   state_t          next_state;
   logic            armed;
   logic [MSG_W-1:0] dividend;
   logic [MSG_W-1:0] shreg;
   logic [RW-1:0]   rem;
   logic            mode_q;
   logic            sel_q;
   logic [CW-1:0]   step_cnt;
   logic            calc_last;
   logic            check_fail;
   logic [MSG_W-1:0] load_dividend;

   // One division step: shift the next dividend bit in, subtract the polynomial when the
   // bit shifted out of the W-bit remainder was set.
   function automatic logic [RW-1:0] div_step(input logic [RW-1:0] r, input logic b,
                                              input logic s);
      logic [RW-1:0] nxt;
      logic          fb;
      fb  = s ? r[PB_W-1] : r[PA_W-1];
      nxt = {r[RW-2:0], b} & (s ? MASK_B : MASK_A);
      if (fb) nxt = nxt ^ (s ? POLY_B_LO : POLY_A_LO);
      return nxt;
   endfunction

   function automatic logic [RW-1:0] div_bpc(input logic [RW-1:0] r,
                                             input logic [BPC-1:0] bits, input logic s);
      logic [RW-1:0] acc;
      acc = r;
      for (int i = BPC - 1; i >= 0; i--) acc = div_step(acc, bits[i], s);
      return acc;
   endfunction

   assign calc_last  = (state == CALC) && (step_cnt == CW'(N));
   assign check_fail = calc_last && mode_q && (rem != '0);

   always_comb begin
      load_dividend = in_msg;
      if (!in_mode) load_dividend = in_sel ? (in_msg << PB_W) : (in_msg << PA_W);
   end

   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid && in_ready) next_state = CALC;
         CALC:    if (calc_last)            next_state = DONE;
         DONE:    if (out_ready)            next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) && armed;
      out_valid = (state == DONE);
   end

   // The extra CALC cycle after the last step turns the remainder into the result word,
   // which gives the N+1 edge latency from accept to out_valid.
   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         armed    <= 1'b0;
         dividend <= '0;
         shreg    <= '0;
         rem      <= '0;
         mode_q   <= 1'b0;
         sel_q    <= 1'b0;
         step_cnt <= '0;
         out_data <= '0;
         out_err  <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  dividend <= load_dividend;
                  shreg    <= load_dividend;
                  rem      <= '0;
                  mode_q   <= in_mode;
                  sel_q    <= in_sel;
                  step_cnt <= '0;
               end
            end
            CALC: begin
               if (calc_last) begin
                  if (!mode_q) begin
                     out_data <= dividend | MSG_W'(rem);
                     out_err  <= 1'b0;
                  end else begin
                     out_data <= (rem != '0) ? '1 : '0;
                     out_err  <= (rem != '0);
                  end
               end else begin
                  rem      <= div_bpc(rem, shreg[MSG_W-1 -: BPC], sel_q);
                  shreg    <= shreg << BPC;
                  step_cnt <= step_cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_data <= '0;
                  out_err  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n)                          err_cnt <= '0;
      else if (err_clr)                    err_cnt <= '0;
      else if (check_fail && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: BPC=1 and BPC=4 instances checked against
// hand-computed CRC results, handshake holding, counter saturation and reset.
module tb_crc_stream_engine;

   localparam logic [59:0] ONES = 60'hFFF_FFFF_FFFF_FFFF;

   logic        clk_1 = 1'b0;
   logic        rst_n = 1'b0;
   logic        err_clr = 1'b0;

   logic        in_valid_1 = 1'b0, in_mode_1 = 1'b0, in_sel_1 = 1'b0, out_ready_1 = 1'b0;
   logic [59:0] in_msg_1 = '0;
   logic        in_ready_1, out_valid_1, out_err_1;
   logic [59:0] out_data_1;
   logic [7:0]  err_cnt_1;

   logic        in_valid_4 = 1'b0, in_mode_4 = 1'b0, in_sel_4 = 1'b0, out_ready_4 = 1'b0;
   logic [59:0] in_msg_4 = '0;
   logic        in_ready_4, out_valid_4, out_err_4;
   logic [59:0] out_data_4;
   logic [7:0]  err_cnt_4;

   int checks = 0;
   int failures = 0;

   always #5 clk_1 = ~clk_1;

   crc_stream_engine #(.BPC(1)) dut_1 (
      .clk_1(clk_1), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
      .in_msg(in_msg_1), .in_mode(in_mode_1), .in_sel(in_sel_1), .out_valid(out_valid_1),
      .out_ready(out_ready_1), .out_data(out_data_1), .out_err(out_err_1),
      .err_clr(err_clr), .err_cnt(err_cnt_1));

   crc_stream_engine #(.BPC(4)) dut_4 (
      .clk_1(clk_1), .rst_n(rst_n), .in_valid(in_valid_4), .in_ready(in_ready_4),
      .in_msg(in_msg_4), .in_mode(in_mode_4), .in_sel(in_sel_4), .out_valid(out_valid_4),
      .out_ready(out_ready_4), .out_data(out_data_4), .out_err(out_err_4),
      .err_clr(err_clr), .err_cnt(err_cnt_4));

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic rdy(input int inst);
      return (inst == 1) ? in_ready_1 : in_ready_4;
   endfunction

   function automatic logic ovalid(input int inst);
      return (inst == 1) ? out_valid_1 : out_valid_4;
   endfunction

   function automatic logic [59:0] odata(input int inst);
      return (inst == 1) ? out_data_1 : out_data_4;
   endfunction

   function automatic logic oerr(input int inst);
      return (inst == 1) ? out_err_1 : out_err_4;
   endfunction

   task automatic drive(input int inst, input logic v, input logic mode, input logic sel,
                        input logic [59:0] msg);
      if (inst == 1) begin
         in_valid_1 = v; in_mode_1 = mode; in_sel_1 = sel; in_msg_1 = msg;
      end else begin
         in_valid_4 = v; in_mode_4 = mode; in_sel_4 = sel; in_msg_4 = msg;
      end
   endtask

   task automatic setReady(input int inst, input logic r);
      if (inst == 1) out_ready_1 = r;
      else           out_ready_4 = r;
   endtask

   // Returns #1 after the accepting edge with in_valid dropped and in_msg scrambled,
   // so any late sampling of the inputs would corrupt the result.
   task automatic acceptOnly(input int inst, input logic mode, input logic sel,
                             input logic [59:0] msg, input string tag);
      int waitc;
      @(negedge clk_1);
      drive(inst, 1'b1, mode, sel, msg);
      waitc = 0;
      while (!rdy(inst) && waitc < 100) begin
         @(negedge clk_1);
         waitc++;
      end
      checkOutput({tag, "_accept"}, {63'd0, rdy(inst)}, 64'd1);
      @(posedge clk_1);
      #1;
      drive(inst, 1'b0, ~mode, ~sel, ~msg);
   endtask

   task automatic waitValid(input int inst, output int lat);
      lat = 0;
      while (!ovalid(inst) && lat < 200) begin
         @(posedge clk_1);
         lat++;
         #1;
      end
   endtask

   task automatic drain(input int inst, input string tag);
      @(negedge clk_1);
      setReady(inst, 1'b1);
      @(posedge clk_1);
      #1;
      checkOutput({tag, "_drain_valid"}, {63'd0, ovalid(inst)}, 64'd0);
      checkOutput({tag, "_drain_data"}, {4'd0, odata(inst)}, 64'd0);
      checkOutput({tag, "_drain_ready"}, {63'd0, rdy(inst)}, 64'd1);
      setReady(inst, 1'b0);
   endtask

   task automatic applyStimulus(input int inst, input logic mode, input logic sel,
                                input logic [59:0] msg, input logic [59:0] exp_data,
                                input logic exp_err, input int exp_lat, input string tag);
      int lat;
      acceptOnly(inst, mode, sel, msg, tag);
      waitValid(inst, lat);
      checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      checkOutput({tag, "_data"}, {4'd0, odata(inst)}, {4'd0, exp_data});
      checkOutput({tag, "_err"}, {63'd0, oerr(inst)}, {63'd0, exp_err});
      drain(inst, tag);
   endtask

   initial begin
      int lat;

      repeat (3) @(posedge clk_1);
      #1;
      checkOutput("rst_in_ready", {63'd0, in_ready_1}, 64'd0);
      checkOutput("rst_out_valid", {63'd0, out_valid_1}, 64'd0);
      checkOutput("rst_out_data", {4'd0, out_data_1}, 64'd0);
      checkOutput("rst_err_cnt", {56'd0, err_cnt_1}, 64'd0);
      @(negedge clk_1);
      rst_n = 1'b1;
      @(posedge clk_1);
      #1;
      checkOutput("post_rst_ready", {63'd0, in_ready_1}, 64'd1);

      applyStimulus(1, 1'b0, 1'b0, 60'h1, 60'h131, 1'b0, 61, "gen_a");
      applyStimulus(1, 1'b0, 1'b1, 60'h1, 60'h2B, 1'b0, 61, "gen_b");
      applyStimulus(1, 1'b0, 1'b1, 60'hF80_0000_0000_0001, 60'h2B, 1'b0, 61, "gen_b_top");
      applyStimulus(1, 1'b1, 1'b0, 60'h131, 60'h0, 1'b0, 61, "chk_pass");
      checkOutput("chk_pass_cnt", {56'd0, err_cnt_1}, 64'd0);
      applyStimulus(1, 1'b1, 1'b0, 60'h132, ONES, 1'b1, 61, "chk_fail");
      checkOutput("chk_fail_cnt", {56'd0, err_cnt_1}, 64'd1);
      applyStimulus(1, 1'b0, 1'b0, 60'h2, 60'h262, 1'b0, 61, "gen_a_2");

      applyStimulus(4, 1'b0, 1'b0, 60'h1, 60'h131, 1'b0, 16, "bpc4_gen_a");
      applyStimulus(4, 1'b0, 1'b1, 60'hF80_0000_0000_0001, 60'h2B, 1'b0, 16, "bpc4_gen_b");
      applyStimulus(4, 1'b1, 1'b0, 60'h131, 60'h0, 1'b0, 16, "bpc4_chk_pass");
      applyStimulus(4, 1'b1, 1'b0, 60'h132, ONES, 1'b1, 16, "bpc4_chk_fail");
      checkOutput("bpc4_cnt", {56'd0, err_cnt_4}, 64'd1);

      // Backpressure: result must hold and a new request must not be taken or queued.
      acceptOnly(1, 1'b0, 1'b0, 60'h1, "hold");
      waitValid(1, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_1);
         drive(1, 1'b1, 1'b1, 1'b0, 60'h132);
         @(posedge clk_1);
         #1;
         checkOutput("hold_valid", {63'd0, out_valid_1}, 64'd1);
         checkOutput("hold_data", {4'd0, out_data_1}, 64'h131);
         checkOutput("hold_ready", {63'd0, in_ready_1}, 64'd0);
      end
      @(negedge clk_1);
      drive(1, 1'b0, 1'b0, 1'b0, 60'h0);
      drain(1, "hold");
      repeat (3) @(posedge clk_1);
      #1;
      checkOutput("hold_no_queue", {63'd0, out_valid_1}, 64'd0);
      checkOutput("hold_no_queue_cnt", {56'd0, err_cnt_1}, 64'd1);

      @(negedge clk_1);
      err_clr = 1'b1;
      @(negedge clk_1);
      err_clr = 1'b0;
      checkOutput("clr_cnt", {56'd0, err_cnt_1}, 64'd0);
      for (int i = 0; i < 255; i++)
         applyStimulus(1, 1'b1, 1'b0, 60'h132, ONES, 1'b1, 61, "sat_run");
      checkOutput("sat_255", {56'd0, err_cnt_1}, 64'd255);
      for (int i = 0; i < 2; i++)
         applyStimulus(1, 1'b1, 1'b1, 60'h1, ONES, 1'b1, 61, "sat_over");
      checkOutput("sat_hold", {56'd0, err_cnt_1}, 64'd255);

      acceptOnly(1, 1'b1, 1'b0, 60'h132, "clr_race");
      repeat (60) @(posedge clk_1);
      @(negedge clk_1);
      err_clr = 1'b1;
      @(posedge clk_1);
      #1;
      err_clr = 1'b0;
      checkOutput("clr_race_valid", {63'd0, out_valid_1}, 64'd1);
      checkOutput("clr_race_cnt", {56'd0, err_cnt_1}, 64'd0);
      drain(1, "clr_race");

      applyStimulus(1, 1'b1, 1'b0, 60'h132, ONES, 1'b1, 61, "pre_rst");
      checkOutput("pre_rst_cnt", {56'd0, err_cnt_1}, 64'd1);
      acceptOnly(1, 1'b1, 1'b0, 60'h132, "mid_rst");
      repeat (10) @(posedge clk_1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", {63'd0, out_valid_1}, 64'd0);
      checkOutput("mid_rst_ready", {63'd0, in_ready_1}, 64'd0);
      checkOutput("mid_rst_data", {4'd0, out_data_1}, 64'd0);
      checkOutput("mid_rst_cnt", {56'd0, err_cnt_1}, 64'd0);
      @(negedge clk_1);
      rst_n = 1'b1;
      repeat (70) @(posedge clk_1);
      #1;
      checkOutput("mid_rst_dropped", {63'd0, out_valid_1}, 64'd0);
      checkOutput("mid_rst_ready_back", {63'd0, in_ready_1}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
